// File: rtl/div_pkg.sv
// Shared types and constants for the MIPS DIV/DIVU sequencer.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_PREP = 2'd1,
        DIV_ITER = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    localparam int DIV_STEPS = 32;
    localparam int DIV_CNT_W = 5;

endpackage

// File: rtl/div_sequencer_if.sv
// EX-stage divide request/result bundle; master is the pipeline, slave is the sequencer.
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             annul_i;
    logic             stall_o;
    logic             busy_o;
    logic             hilo_we_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, signed_i, a_i, b_i, annul_i,
        input  stall_o, busy_o, hilo_we_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, signed_i, a_i, b_i, annul_i,
        output stall_o, busy_o, hilo_we_o, hi_o, lo_o
    );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step; purely combinational, no latency, no backpressure.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_STEPS
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next,
    output logic             q_bit
);
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        // Keep the bit shifted out of rem so the trial sign is exact at WIDTH+1 bits.
        rem_sh   = {rem, quo[WIDTH-1]};
        trial    = rem_sh - {1'b0, divisor};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], q_bit};
    end
endmodule

// File: rtl/div_sequencer.sv
// DIV/DIVU sequencer: accept, PREP, 32 ITER steps, DONE strobe (34 stall cycles; 1 for divide by zero).
// Backpressure is the stall output itself; annul aborts on the next edge and drops stall/strobe at once.
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_STEPS
) (
    input  logic           clk,
    input  logic           resetn,
    div_sequencer_if.slave div
);
    localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(WIDTH - 1);

    div_state_t           state;
    logic [DIV_CNT_W-1:0] cnt;
    logic                 sgn;
    logic                 neg_q;
    logic                 neg_r;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic [WIDTH-1:0]     rem_nx;
    logic [WIDTH-1:0]     quo_nx;
    logic                 q_bit;
    logic [WIDTH-1:0]     quo_fin;
    logic                 a_neg;
    logic                 b_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_nx),
        .quo_next (quo_nx),
        .q_bit    (q_bit)
    );

    assign quo_fin = {quo[WIDTH-2:0], q_bit};
    assign a_neg   = sgn & quo[WIDTH-1];
    assign b_neg   = sgn & divisor[WIDTH-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            sgn     <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (div.annul_i) begin
            state <= DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (div.start_i) begin
                        sgn     <= div.signed_i;
                        quo     <= div.a_i;
                        divisor <= div.b_i;
                        if (div.b_i == '0) begin
                            hi_q  <= div.a_i;
                            lo_q  <= '1;
                            state <= DIV_DONE;
                        end else begin
                            state <= DIV_PREP;
                        end
                    end
                end
                DIV_PREP: begin
                    // Operands were latched raw; fold signs into magnitudes here.
                    neg_q   <= a_neg ^ b_neg;
                    neg_r   <= a_neg;
                    quo     <= a_neg ? -quo : quo;
                    divisor <= b_neg ? -divisor : divisor;
                    rem     <= '0;
                    cnt     <= '0;
                    state   <= DIV_ITER;
                end
                DIV_ITER: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        lo_q  <= neg_q ? -quo_fin : quo_fin;
                        hi_q  <= neg_r ? -rem_nx : rem_nx;
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    assign div.stall_o   = resetn & ~div.annul_i &
                           (((state == DIV_IDLE) & div.start_i) |
                            (state == DIV_PREP) | (state == DIV_ITER));
    assign div.busy_o    = (state != DIV_IDLE);
    assign div.hilo_we_o = (state == DIV_DONE) & ~div.annul_i;
    assign div.hi_o      = hi_q;
    assign div.lo_o      = lo_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, results, divide-by-zero, overflow, annul and async reset.
module tb_div_sequencer;
    logic clk;
    logic resetn;
    int   vectors;
    int   errors;

    div_sequencer_if #(.WIDTH(32)) dif ();

    div_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .div    (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue one request at the current cycle; follow it to the strobe and one cycle beyond.
    task automatic do_div(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] elo,
                          input logic [31:0] ehi, input logic annul_done);
        int c;
        c = 0;
        dif.start_i  = 1'b1;
        dif.signed_i = s;
        dif.a_i      = a;
        dif.b_i      = b;
        #1;
        while (dif.hilo_we_o !== 1'b1 && c < 100) begin
            chk({tag, "_stall"}, {31'd0, dif.stall_o}, 32'd1);
            tick();
            #1;
            c++;
        end
        chk({tag, "_latency"}, c, lat);
        chk({tag, "_done_stall"}, {31'd0, dif.stall_o}, 32'd0);
        if (annul_done) begin
            dif.annul_i = 1'b1;
            #1;
            chk({tag, "_we_annulled"}, {31'd0, dif.hilo_we_o}, 32'd0);
        end else begin
            chk({tag, "_lo"}, dif.lo_o, elo);
            chk({tag, "_hi"}, dif.hi_o, ehi);
        end
        tick();
        dif.start_i = 1'b0;
        dif.annul_i = 1'b0;
        #1;
        chk({tag, "_no_rewrite"}, {31'd0, dif.hilo_we_o}, 32'd0);
        chk({tag, "_idle"}, {31'd0, dif.busy_o}, 32'd0);
        if (!annul_done) begin
            chk({tag, "_lo_hold"}, dif.lo_o, elo);
            chk({tag, "_hi_hold"}, dif.hi_o, ehi);
        end
    endtask

    initial begin
        vectors      = 0;
        errors       = 0;
        resetn       = 1'b0;
        dif.start_i  = 1'b0;
        dif.signed_i = 1'b0;
        dif.a_i      = '0;
        dif.b_i      = '0;
        dif.annul_i  = 1'b0;
        #12;
        chk("rst_busy", {31'd0, dif.busy_o}, 32'd0);
        chk("rst_stall", {31'd0, dif.stall_o}, 32'd0);
        chk("rst_we", {31'd0, dif.hilo_we_o}, 32'd0);
        chk("rst_hi", dif.hi_o, 32'd0);
        chk("rst_lo", dif.lo_o, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        do_div("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 34, 32'h7FFF_FFFC, 32'd1, 1'b0);
        do_div("div_by_zero", 1'b1, 32'h0000_1234, 32'd0, 1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b0);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'd0, 1'b0);
        do_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 34, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

        // Annul in the middle of ITER, then a fresh request two cycles later.
        dif.start_i  = 1'b1;
        dif.signed_i = 1'b0;
        dif.a_i      = 32'd100;
        dif.b_i      = 32'd7;
        for (int i = 0; i < 10; i++) tick();
        dif.annul_i = 1'b1;
        #1;
        chk("annul_stall_drop", {31'd0, dif.stall_o}, 32'd0);
        chk("annul_we", {31'd0, dif.hilo_we_o}, 32'd0);
        chk("annul_busy_before", {31'd0, dif.busy_o}, 32'd1);
        tick();
        dif.annul_i = 1'b0;
        dif.start_i = 1'b0;
        #1;
        chk("annul_idle", {31'd0, dif.busy_o}, 32'd0);
        chk("annul_no_we", {31'd0, dif.hilo_we_o}, 32'd0);
        tick();
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 34, 32'd3, 32'd0, 1'b0);

        do_div("annul_at_done", 1'b0, 32'd50, 32'd5, 34, 32'd10, 32'd0, 1'b1);

        // Asynchronous reset in the middle of a clock period during ITER.
        dif.start_i  = 1'b1;
        dif.signed_i = 1'b0;
        dif.a_i      = 32'd100;
        dif.b_i      = 32'd7;
        for (int i = 0; i < 20; i++) tick();
        #1;
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, dif.busy_o}, 32'd0);
        chk("mid_rst_stall", {31'd0, dif.stall_o}, 32'd0);
        chk("mid_rst_we", {31'd0, dif.hilo_we_o}, 32'd0);
        chk("mid_rst_hi", dif.hi_o, 32'd0);
        chk("mid_rst_lo", dif.lo_o, 32'd0);
        dif.start_i = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        do_div("divu_15_4", 1'b0, 32'd15, 32'd4, 34, 32'd3, 32'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
